// File: rtl/qif_spike_monitor_if.sv
// rtl/qif_spike_monitor_if.sv - membrane-potential sample and spike readout bundle
//
// Purpose: groups the sample-side inputs and readout outputs of qif_spike_monitor.
// Ports (signals):
//   en          sample enable, low holds everything
//   v           membrane potential, unsigned
//   thresh      spike threshold, unsigned
//   spike       one-cycle spike pulse
//   spike_count spikes in last completed window (saturating)
//   count_valid one-cycle pulse when spike_count updates
//   isi         enabled cycles between the last two detections (saturating)
//   isi_valid   one-cycle pulse when isi updates
// Modports: master drives samples and reads results; slave is the monitor.
interface qif_spike_monitor_if #(
  parameter int V_W   = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 16
);
  logic             en;
  logic [V_W-1:0]   v;
  logic [V_W-1:0]   thresh;
  logic             spike;
  logic [CNT_W-1:0] spike_count;
  logic             count_valid;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;

  modport master (
    output en, v, thresh,
    input  spike, spike_count, count_valid, isi, isi_valid
  );

  modport slave (
    input  en, v, thresh,
    output spike, spike_count, count_valid, isi, isi_valid
  );
endinterface

// File: rtl/qif_spike_monitor.sv
// rtl/qif_spike_monitor.sv - threshold spike detector with refractory, ISI and windowed rate
//
// Purpose: samples the QIF membrane potential every enabled cycle, detects threshold
// crossings with hysteresis and a refractory period, and reports spike pulses,
// inter-spike interval and per-window spike count. All outputs are registered.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  qif_spike_monitor_if.slave (en, v, thresh in; spike, spike_count,
//        count_valid, isi, isi_valid out)
module qif_spike_monitor #(
  parameter int V_W     = 8,
  parameter int CNT_W   = 8,
  parameter int ISI_W   = 16,
  parameter int WINDOW  = 256,
  parameter int REFRACT = 4
) (
  input logic                 clk,
  input logic                 rst,
  qif_spike_monitor_if.slave  bus
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {ARMED, HIGH, REFR} state_t;

  state_t           state_q, state_d;
  logic [REF_W-1:0] refr_q, refr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] run_q, run_d, run_next;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic             have_prev_q, have_prev_d;
  logic             spike_q, spike_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic [V_W-1:0]   v_s, thresh_s;
  logic             det;

  assign v_s      = bus.v;
  assign thresh_s = bus.thresh;

  always_comb begin
    state_d       = state_q;
    refr_d        = refr_q;
    win_d         = win_q;
    run_d         = run_q;
    run_next      = run_q;
    isi_cnt_d     = isi_cnt_q;
    have_prev_d   = have_prev_q;
    count_d       = count_q;
    isi_d         = isi_q;
    spike_d       = 1'b0;
    count_valid_d = 1'b0;
    isi_valid_d   = 1'b0;
    det           = 1'b0;

    if (bus.en) begin
      case (state_q)
        ARMED: begin
          if (v_s >= thresh_s) begin
            det     = 1'b1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          // Hysteresis: re-arm only after the potential has dropped below threshold.
          if (v_s < thresh_s) begin
            if (REFRACT == 0) begin
              state_d = ARMED;
            end else begin
              refr_d  = REF_W'(REFRACT);
              state_d = REFR;
            end
          end
        end
        REFR: begin
          // Counter reaches 0 after exactly REFRACT enabled cycles in this state.
          if (refr_q <= REF_W'(1)) begin
            refr_d  = '0;
            state_d = ARMED;
          end else begin
            refr_d = refr_q - REF_W'(1);
          end
        end
        default: state_d = ARMED;
      endcase

      // The counter holds the distance to the previous detection at sample time.
      if (det) begin
        isi_cnt_d   = ISI_W'(1);
        have_prev_d = 1'b1;
        if (have_prev_q) begin
          isi_d       = isi_cnt_q;
          isi_valid_d = 1'b1;
        end
      end else if (isi_cnt_q != '1) begin
        isi_cnt_d = isi_cnt_q + ISI_W'(1);
      end

      spike_d = det;

      // A detection on the terminal sample still belongs to the closing window.
      if (det && (run_q != '1)) begin
        run_next = run_q + CNT_W'(1);
      end
      if (win_q == WIN_LAST) begin
        count_d       = run_next;
        count_valid_d = 1'b1;
        run_d         = '0;
        win_d         = '0;
      end else begin
        run_d = run_next;
        win_d = win_q + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARMED;
      refr_q        <= '0;
      win_q         <= '0;
      run_q         <= '0;
      isi_cnt_q     <= '0;
      have_prev_q   <= 1'b0;
      spike_q       <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      isi_q         <= '0;
      isi_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      refr_q        <= refr_d;
      win_q         <= win_d;
      run_q         <= run_d;
      isi_cnt_q     <= isi_cnt_d;
      have_prev_q   <= have_prev_d;
      spike_q       <= spike_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      isi_q         <= isi_d;
      isi_valid_q   <= isi_valid_d;
    end
  end

  assign bus.spike       = spike_q;
  assign bus.spike_count = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.isi         = isi_q;
  assign bus.isi_valid   = isi_valid_q;
endmodule

// File: tb/tb_qif_spike_monitor.sv
// tb/tb_qif_spike_monitor.sv - self-checking bench for qif_spike_monitor
module tb_qif_spike_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] v = 8'd0;
  logic [7:0] thresh = 8'd0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // a: REFRACT=4 defaults; b: ISI_W=4; c: WINDOW=16, CNT_W=2, REFRACT=0
  qif_spike_monitor_if #(.V_W(8), .CNT_W(8), .ISI_W(16)) if_a ();
  qif_spike_monitor_if #(.V_W(8), .CNT_W(8), .ISI_W(4))  if_b ();
  qif_spike_monitor_if #(.V_W(8), .CNT_W(2), .ISI_W(16)) if_c ();

  assign if_a.en = en; assign if_a.v = v; assign if_a.thresh = thresh;
  assign if_b.en = en; assign if_b.v = v; assign if_b.thresh = thresh;
  assign if_c.en = en; assign if_c.v = v; assign if_c.thresh = thresh;

  qif_spike_monitor #(.V_W(8), .CNT_W(8), .ISI_W(16), .WINDOW(256), .REFRACT(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  qif_spike_monitor #(.V_W(8), .CNT_W(8), .ISI_W(4), .WINDOW(256), .REFRACT(4))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  qif_spike_monitor #(.V_W(8), .CNT_W(2), .ISI_W(16), .WINDOW(16), .REFRACT(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  logic        o_spk[3], o_cv[3], o_iv[3];
  logic [15:0] o_cnt[3], o_isi[3];
  assign o_spk[0] = if_a.spike; assign o_cv[0] = if_a.count_valid; assign o_iv[0] = if_a.isi_valid;
  assign o_spk[1] = if_b.spike; assign o_cv[1] = if_b.count_valid; assign o_iv[1] = if_b.isi_valid;
  assign o_spk[2] = if_c.spike; assign o_cv[2] = if_c.count_valid; assign o_iv[2] = if_c.isi_valid;
  assign o_cnt[0] = 16'(if_a.spike_count); assign o_isi[0] = 16'(if_a.isi);
  assign o_cnt[1] = 16'(if_b.spike_count); assign o_isi[1] = 16'(if_b.isi);
  assign o_cnt[2] = 16'(if_c.spike_count); assign o_isi[2] = 16'(if_c.isi);

  // Reference model: works on enabled-sample indices and detection times.
  int p_ref[3]  = '{4, 4, 0};
  int p_win[3]  = '{256, 256, 16};
  int p_cmax[3] = '{255, 255, 3};
  int p_imax[3] = '{65535, 15, 65535};
  int m_idx[3], m_ready[3], m_last[3], m_run[3];
  bit m_wait[3], m_have[3];
  int e_cnt[3], e_isi[3];
  bit e_spk[3], e_cv[3], e_iv[3];

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit det;
      det = 1'b0;
      if (rst) begin
        m_idx[k] = 0; m_ready[k] = 0; m_last[k] = 0; m_run[k] = 0;
        m_wait[k] = 0; m_have[k] = 0;
        e_cnt[k] = 0; e_isi[k] = 0; e_spk[k] = 0; e_cv[k] = 0; e_iv[k] = 0;
      end else if (!en) begin
        e_spk[k] = 0; e_cv[k] = 0; e_iv[k] = 0;
      end else begin
        if (m_wait[k]) begin
          if (v < thresh) begin
            m_wait[k]  = 0;
            m_ready[k] = m_idx[k] + 1 + p_ref[k];
          end
        end else if (m_idx[k] >= m_ready[k] && v >= thresh) begin
          det = 1'b1;
        end
        e_spk[k] = det;
        e_iv[k]  = 0;
        if (det) begin
          if (m_have[k]) begin
            e_iv[k]  = 1;
            e_isi[k] = (m_idx[k] - m_last[k] > p_imax[k]) ? p_imax[k] : m_idx[k] - m_last[k];
          end
          m_have[k] = 1;
          m_last[k] = m_idx[k];
          m_wait[k] = 1;
          if (m_run[k] < p_cmax[k]) m_run[k] = m_run[k] + 1;
        end
        if (m_idx[k] % p_win[k] == p_win[k] - 1) begin
          e_cnt[k] = m_run[k];
          e_cv[k]  = 1;
          m_run[k] = 0;
        end else begin
          e_cv[k] = 0;
        end
        m_idx[k] = m_idx[k] + 1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic [7:0] vv, input logic [7:0] tt);
    rst = r; en = e; v = vv; thresh = tt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 8'd255, 8'd0);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if ({o_spk[k], o_cv[k], o_iv[k]} !== 3'b000 || o_cnt[k] !== 16'd0 || o_isi[k] !== 16'd0) begin
          fails++;
          $display("FAIL reset_outputs dut%0d cyc%0d: got spk=%b cv=%b iv=%b cnt=%0d isi=%0d expected all 0",
                   k, i, o_spk[k], o_cv[k], o_iv[k], o_cnt[k], o_isi[k]);
        end
      end
    end
    tick(1'b0, 1'b1, 8'd255, 8'd0);
    tests++;
    if (o_spk[0] !== 1'b1) begin
      fails++; $display("FAIL reset_first_spike: got %b expected 1", o_spk[0]);
    end
    tests++;
    if (o_iv[0] !== 1'b0) begin
      fails++; $display("FAIL reset_first_isi_valid: got %b expected 0", o_iv[0]);
    end
  endtask

  task automatic test_single_crossing();
    int ramp[7] = '{0, 50, 99, 100, 150, 150, 0};
    tick(1'b1, 1'b1, 8'd0, 8'd100);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 8'(ramp[i]), 8'd100);
      tests++;
      if (o_spk[0] !== (i == 3)) begin
        fails++; $display("FAIL single_spike sample%0d: got %b expected %b", i, o_spk[0], (i == 3));
      end
      tests++;
      if (o_iv[0] !== 1'b0) begin
        fails++; $display("FAIL single_isi_valid sample%0d: got %b expected 0", i, o_iv[0]);
      end
    end
  endtask

  task automatic test_refractory();
    tick(1'b1, 1'b1, 8'd0, 8'd100);
    for (int i = 0; i < 30; i++) begin
      logic exp_det;
      exp_det = (i % 6 == 0);
      tick(1'b0, 1'b1, (i % 2 == 0) ? 8'd200 : 8'd0, 8'd100);
      tests++;
      if (o_spk[0] !== exp_det) begin
        fails++; $display("FAIL refr_spike sample%0d: got %b expected %b", i, o_spk[0], exp_det);
      end
      tests++;
      if (o_iv[0] !== (exp_det && i > 0)) begin
        fails++; $display("FAIL refr_isi_valid sample%0d: got %b expected %b", i, o_iv[0], exp_det && i > 0);
      end
      if (exp_det && i > 0) begin
        tests++;
        if (o_isi[0] !== 16'd6) begin
          fails++; $display("FAIL refr_isi sample%0d: got %0d expected 6", i, o_isi[0]);
        end
      end
    end
  endtask

  task automatic test_isi_saturation();
    tick(1'b1, 1'b1, 8'd0, 8'd100);
    for (int i = 0; i <= 70; i++) begin
      logic hit;
      hit = (i == 10 || i == 22 || i == 62);
      tick(1'b0, 1'b1, hit ? 8'd200 : 8'd0, 8'd100);
      tests++;
      if (o_spk[1] !== hit) begin
        fails++; $display("FAIL isi_spike sample%0d: got %b expected %b", i, o_spk[1], hit);
      end
      tests++;
      if (o_iv[1] !== (i == 22 || i == 62)) begin
        fails++; $display("FAIL isi_valid sample%0d: got %b expected %b", i, o_iv[1], (i == 22 || i == 62));
      end
      if (i == 22) begin
        tests++;
        if (o_isi[1] !== 16'd12) begin
          fails++; $display("FAIL isi_value: got %0d expected 12", o_isi[1]);
        end
      end
      if (i == 62) begin
        tests++;
        if (o_isi[1] !== 16'd15) begin
          fails++; $display("FAIL isi_saturated: got %0d expected 15", o_isi[1]);
        end
      end
    end
  endtask

  task automatic test_window_count();
    tick(1'b1, 1'b1, 8'd0, 8'd100);
    for (int i = 0; i < 36; i++) begin
      logic hit;
      hit = (i == 1 || i == 3 || i == 5 || i == 7 || i == 15 || i == 20 || i == 31);
      tick(1'b0, 1'b1, hit ? 8'd200 : 8'd0, 8'd100);
      tests++;
      if (o_spk[2] !== hit) begin
        fails++; $display("FAIL win_spike sample%0d: got %b expected %b", i, o_spk[2], hit);
      end
      tests++;
      if (o_cv[2] !== (i == 15 || i == 31)) begin
        fails++; $display("FAIL win_count_valid sample%0d: got %b expected %b", i, o_cv[2], (i == 15 || i == 31));
      end
      if (i == 15 || i == 31) begin
        tests++;
        if (o_cnt[2] !== ((i == 15) ? 16'd3 : 16'd2)) begin
          fails++; $display("FAIL win_spike_count sample%0d: got %0d expected %0d", i, o_cnt[2], (i == 15) ? 3 : 2);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    tick(1'b1, 1'b1, 8'd0, 8'd100);
    tick(1'b0, 1'b1, 8'd200, 8'd100);   // enabled sample 0: detect
    tick(1'b0, 1'b1, 8'd0, 8'd100);     // sample 1: fall, refractory loaded
    tick(1'b0, 1'b1, 8'd0, 8'd100);     // sample 2: first refractory cycle
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 8'd255, 8'd100);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if ({o_spk[k], o_cv[k], o_iv[k]} !== 3'b000) begin
          fails++; $display("FAIL hold_pulses dut%0d cyc%0d: got spk=%b cv=%b iv=%b expected 0", k, i, o_spk[k], o_cv[k], o_iv[k]);
        end
        tests++;
        if (o_cnt[k] !== 16'(e_cnt[k]) || o_isi[k] !== 16'(e_isi[k])) begin
          fails++; $display("FAIL hold_values dut%0d cyc%0d: got cnt=%0d isi=%0d expected cnt=%0d isi=%0d", k, i, o_cnt[k], o_isi[k], e_cnt[k], e_isi[k]);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 1'b1, 8'd255, 8'd100); // enabled samples 3..6
      tests++;
      if (o_spk[0] !== (j == 3)) begin
        fails++; $display("FAIL hold_refr_resume sample%0d: got %b expected %b", j + 3, o_spk[0], (j == 3));
      end
      if (j == 3) begin
        tests++;
        if (o_iv[0] !== 1'b1 || o_isi[0] !== 16'd6) begin
          fails++; $display("FAIL hold_isi: got iv=%b isi=%0d expected iv=1 isi=6", o_iv[0], o_isi[0]);
        end
      end
    end
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 1'b1, 8'd0, 8'd100);   // enabled samples 7..18
      tests++;
      if (o_cv[2] !== (j + 7 == 15)) begin
        fails++; $display("FAIL hold_window_pos sample%0d: got %b expected %b", j + 7, o_cv[2], (j + 7 == 15));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] tt;
    tick(1'b1, 1'b1, 8'd0, 8'd0);
    tt = 8'($urandom_range(40, 200));
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) tt = 8'($urandom_range(0, 255));
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), 8'($urandom_range(0, 255)), tt);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (o_spk[k] !== e_spk[k]) begin
          fails++; $display("FAIL rand_spike dut%0d cyc%0d: got %b expected %b", k, i, o_spk[k], e_spk[k]);
        end
        tests++;
        if (o_cv[k] !== e_cv[k] || o_cnt[k] !== 16'(e_cnt[k])) begin
          fails++; $display("FAIL rand_count dut%0d cyc%0d: got cv=%b cnt=%0d expected cv=%b cnt=%0d", k, i, o_cv[k], o_cnt[k], e_cv[k], e_cnt[k]);
        end
        tests++;
        if (o_iv[k] !== e_iv[k] || o_isi[k] !== 16'(e_isi[k])) begin
          fails++; $display("FAIL rand_isi dut%0d cyc%0d: got iv=%b isi=%0d expected iv=%b isi=%0d", k, i, o_iv[k], o_isi[k], e_iv[k], e_isi[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_crossing();
    test_refractory();
    test_isi_saturation();
    test_window_count();
    test_enable_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qif_spike_monitor.md
# qif_spike_monitor

Downstream stage of the QIF neuron: it samples the neuron's membrane-potential bus every clock and turns it into spike events. It detects threshold crossings with hysteresis and a refractory period, emits a one-cycle spike pulse, and measures inter-spike interval (ISI). It also reports spike count per fixed window, giving the top level a rate/timing readout of the neuron instead of a raw potential.

## Interface

Parameters:
- V_W, 8: width of membrane-potential input and threshold.
- CNT_W, 8: width of per-window spike count (saturating).
- ISI_W, 16: width of ISI measurement (saturating).
- WINDOW, 256: counting window length in enabled cycles, ≥2.
- REFRACT, 4: refractory cycles after potential falls below threshold, ≥0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sample enable; low = full hold.
- v  in  V_W  neuron membrane potential, unsigned.
- thresh  in  V_W  spike threshold, unsigned, sampled every cycle.
- spike  out  1  one-cycle spike pulse.
- spike_count  out  CNT_W  spikes detected in last completed window.
- count_valid  out  1  one-cycle pulse when spike_count updates.
- isi  out  ISI_W  cycles between last two detections.
- isi_valid  out  1  one-cycle pulse when isi updates.

## Operation

- Detector FSM states: ARMED, HIGH, REFR.
  - ARMED: if en and v ≥ thresh, this is a detection. Go to HIGH.
  - HIGH: wait for v < thresh with en high. If REFRACT = 0, go to ARMED; otherwise load the refractory counter with REFRACT and go to REFR.
  - REFR: decrement on each enabled cycle, ignoring v. Go to ARMED when the counter reaches 0, which takes exactly REFRACT enabled cycles.
- Entering ARMED with v ≥ thresh already true detects on the first enabled ARMED cycle.
- Window: a counter advances on each enabled cycle. On the enabled cycle that is the WINDOW-th of the window:
  - the running count, including a detection in that same cycle, is copied to spike_count;
  - count_valid pulses;
  - the running count and window counter clear.
- Running count saturates at 2^CNT_W−1.
- ISI:
  - The ISI counter increments on each enabled cycle, saturating at 2^ISI_W−1.
  - On a detection it resets to 1.
  - A detection at enabled sample index t2 after a previous detection at t1 gives isi = t2−t1 (in enabled cycles), or all-ones if saturated.
  - isi_valid pulses on each such update.
- First detection after reset sets a have_prev flag only: no isi/isi_valid update.
- en low: FSM, all counters, and all outputs hold. Pulses (spike, count_valid, isi_valid) are forced 0 while en is low.
- Arithmetic is unsigned. The thresh compare is full V_W width; no sign interpretation.

## Timing

- All outputs are registered. A detection on sample cycle t gives spike=1 in cycle t+1 only.
- isi/isi_valid update with the same latency as spike.
- count_valid and spike_count update in cycle t+1 after the terminal window sample t.
- Reset values: spike=0, spike_count=0, count_valid=0, isi=0, isi_valid=0.
- Reset internals: FSM=ARMED, all counters=0, have_prev=0.
- rst has priority over en and over any in-flight event.
- Reset in any state (including mid-REFR or mid-window) discards partial counts. The next cycle behaves as post-reset.
- Minimum spacing between detections: 2 + REFRACT sample cycles (one HIGH cycle with v ≥ thresh, one falling sample, REFRACT refractory cycles).
- Threshold changes take effect in the same cycle they are sampled.

## Test plan

- Reset: hold rst 3 cycles with v=255, thresh=0, en=1. All outputs stay 0 during reset. The first post-reset sample detects, and spike=1 exactly one cycle after rst deasserts.
- Single crossing (thresh=100, REFRACT=4): ramp v 0,50,99,100,150,150,0.
  - Exactly one spike, in the cycle after v=100 is sampled.
  - No isi_valid, since it is the first detection.
- Refractory rejection (REFRACT=4, thresh=100): v toggles 200/0 every cycle.
  - Detections occur every 6 samples, with the pattern exactly 200 (detect), 0 (fall), then 4 refractory samples.
  - isi=6 reported from the second detection on.
- ISI + saturation (ISI_W=4):
  - Isolated 1-cycle crossings at sample 10 and sample 22 give isi=12.
  - A later crossing 40 samples on gives isi=15 (saturated).
- Window count (WINDOW=16, CNT_W=2, REFRACT=0): 5 detections in the first window, 2 in the second.
  - count_valid pulses after samples 16 and 32.
  - spike_count = 3 (saturated), then 2.
  - A detection on the terminal sample is included in that window.
- Enable hold: drop en for 10 cycles mid-REFR and mid-window with v=255. No pulses while en is low. After en returns, the refractory remainder, window position and ISI resume unchanged.
